// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        CKSUM  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

    // States in which the loader takes a byte from the stream.
    function automatic logic accepts_bytes(input loader_state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CKSUM);
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Collects four little-endian bytes into one 32-bit word.
module loader_word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              strobe,
    input  logic              clear,
    input  logic [BYTE_W-1:0] in_byte,
    output logic [WORD_W-1:0] word_c,
    output logic              word_full_c
);

    logic [1:0]        count;
    logic [WORD_W-1:0] shreg;

    // Right shift puts the first byte in [7:0] once four bytes have arrived.
    assign word_c      = {in_byte, shreg[WORD_W-1:BYTE_W]};
    assign word_full_c = strobe && (count == 2'd3);

    // Byte counter and shift register; count wraps to 0 after each full word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            shreg <= '0;
        end else if (clear) begin
            count <= 2'd0;
            shreg <= '0;
        end else if (strobe) begin
            count <= count + 2'd1;
            shreg <= word_c;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot-time instruction-memory writer: byte stream in, 32-bit word writes out,
// core held in reset until the image is complete.
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              load_req,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    localparam int unsigned CAPACITY = 32'd1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_LOAD = CKSUM;
`else
    localparam loader_state_t AFTER_LOAD = DONE;
`endif

    loader_state_t     state;
    loader_state_t     next_state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  n_word;
    logic [ADDR_W-1:0] index;
    logic              accept;
    logic              asm_strobe;
    logic              asm_clear;
    logic              restart;
    logic              write_last;
    logic [WORD_W-1:0] word_c;
    logic              word_full_c;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] xor_acc;
`endif

    assign accept = in_valid && in_ready;
    assign n_word = {in_data, len[7:0]};

    loader_word_assembler u_asm (
        .clk         (CLK),
        .rst         (reset),
        .strobe      (asm_strobe),
        .clear       (asm_clear),
        .in_byte     (in_data),
        .word_c      (word_c),
        .word_full_c (word_full_c)
    );

    // Next-state decode and per-state control strobes.
    always_comb begin
        next_state = state;
        asm_strobe = 1'b0;
        asm_clear  = 1'b0;
        restart    = 1'b0;
        write_last = 1'b0;
        case (state)
            LEN_LO: if (accept) next_state = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    asm_clear = 1'b1;
                    if (32'(n_word) > CAPACITY)  next_state = ERROR;
                    else if (n_word == '0)       next_state = AFTER_LOAD;
                    else                         next_state = DATA;
                end
            end
            DATA: begin
                asm_strobe = accept;
                if (accept && word_full_c) next_state = WRITE;
            end
            WRITE: begin
                write_last = (LEN_W'(index) == (len - LEN_W'(1)));
                next_state = write_last ? AFTER_LOAD : DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            CKSUM: if (accept) next_state = (in_data == xor_acc) ? DONE : ERROR;
`endif
            DONE, ERROR: begin
                if (load_req) begin
                    restart    = 1'b1;
                    asm_clear  = 1'b1;
                    next_state = LEN_LO;
                end
            end
            default: next_state = LEN_LO;
        endcase
    end

    // State register and registered output decode from the next state.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state      <= LEN_LO;
            in_ready   <= 1'b1;
            im_we      <= 1'b0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= next_state;
            in_ready   <= accepts_bytes(next_state);
            im_we      <= (next_state == WRITE);
            core_reset <= (next_state != DONE);
            done       <= (next_state == DONE);
            error      <= (next_state == ERROR);
        end
    end

    // Write address/data captured on entry to WRITE, held otherwise.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            im_addr  <= '0;
            im_wdata <= '0;
        end else if (next_state == WRITE) begin
            im_addr  <= index;
            im_wdata <= word_c;
        end
    end

    // Word count capture and word index.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            len   <= '0;
            index <= '0;
        end else begin
            if (state == LEN_LO && accept) len[7:0]  <= in_data;
            if (state == LEN_HI && accept) len[15:8] <= in_data;
            if (restart || (state == LEN_HI && accept))
                index <= '0;
            else if (state == WRITE && !write_last)
                index <= index + ADDR_W'(1);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over the length and data bytes.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            xor_acc <= '0;
        end else if (restart) begin
            xor_acc <= '0;
        end else if (accept && (state == LEN_LO || state == LEN_HI || state == DATA)) begin
            xor_acc <= xor_acc ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader; write expectations are queued as
// stimulus is generated and matched against im_we cycles by a monitor.
module tb_program_loader;

    localparam int unsigned ADDR_W = 10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              CLK = 1'b0;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              load_req;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              core_reset;
    logic              done;
    logic              error;

    int  total = 0;
    int  bad   = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .load_req   (load_req),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: every write strobe must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (im_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected: got addr=%0d data=%08h, required no write", im_addr, im_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (im_addr !== mon_e.addr || im_wdata !== mon_e.data) begin
                    bad++;
                    $display("FAIL write_content: got addr=%0d data=%08h, required addr=%0d data=%08h",
                             im_addr, im_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int budget;
        budget = 0;
        if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge CLK);
        @(negedge CLK);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && budget < 50) begin
            @(negedge CLK);
            budget++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL byte_stall: in_ready=%b after %0d cycles, required 1", in_ready, budget);
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic wait_end(input logic want_done, input string name);
        int budget;
        budget = 0;
        while (done !== 1'b1 && error !== 1'b1 && budget < 60) begin
            @(negedge CLK);
            budget++;
        end
        total++;
        if (done !== want_done || error !== !want_done || core_reset !== !want_done) begin
            bad++;
            $display("FAIL %s_end: got done=%b error=%b core_reset=%b, required done=%b error=%b core_reset=%b",
                     name, done, error, core_reset, want_done, !want_done, !want_done);
        end
    endtask

    task automatic pulse_load_req(input string name);
        @(negedge CLK);
        load_req = 1'b1;
        @(posedge CLK);
        #1;
        load_req = 1'b0;
        total++;
        if (core_reset !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL %s_restart: got core_reset=%b in_ready=%b done=%b error=%b, required 1 1 0 0",
                     name, core_reset, in_ready, done, error);
        end
    endtask

    task automatic load_image(input logic [31:0] words[$], input int max_gap, input string name);
        logic [7:0]  x;
        logic [15:0] n;
        logic [31:0] w;
        x = 8'h00;
        n = 16'(words.size());
        send_byte(n[7:0], max_gap);  x ^= n[7:0];
        send_byte(n[15:8], max_gap); x ^= n[15:8];
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            exp_q.push_back({ADDR_W'(i), w});
            for (int b = 0; b < 4; b++) begin
                send_byte(w[8*b +: 8], max_gap);
                x ^= w[8*b +: 8];
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x, max_gap);
`endif
        wait_end(1'b1, name);
        @(negedge CLK);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_writes: got %0d writes missing, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; load_req = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge CLK);
        total++;
        if ({in_ready, im_we, core_reset, done, error} !== 5'b10100 || im_addr !== '0 || im_wdata !== '0) begin
            bad++;
            $display("FAIL reset_values: got rdy/we/crst/done/err=%b addr=%0d data=%08h, required 10100 0 0",
                     {in_ready, im_we, core_reset, done, error}, im_addr, im_wdata);
        end
        reset = 1'b0;
        exp_q.push_back({ADDR_W'(0), 32'h00100513});
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        send_byte(8'h93, 0); send_byte(8'h05, 0);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({in_ready, im_we, core_reset, done, error} !== 5'b10100 || im_addr !== '0 || im_wdata !== '0) begin
            bad++;
            $display("FAIL reset_async: got rdy/we/crst/done/err=%b addr=%0d data=%08h, required 10100 0 0",
                     {in_ready, im_we, core_reset, done, error}, im_addr, im_wdata);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL reset_first_write: got %0d pending, required 0", exp_q.size());
        end
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        exp_q.push_back({ADDR_W'(0), 32'h00100513});
        exp_q.push_back({ADDR_W'(1), 32'h00200593});
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        send_byte(8'h93, 0); send_byte(8'h05, 0); send_byte(8'h20, 0); send_byte(8'h00, 0);
        @(negedge CLK);
        total++;
        if (im_we !== 1'b1 || done !== 1'b0 || core_reset !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_last_write: got we=%b done=%b crst=%b rdy=%b, required 1 0 1 0",
                     im_we, done, core_reset, in_ready);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hB2, 0);
        @(negedge CLK);
`else
        @(negedge CLK);
`endif
        total++;
        if (im_we !== 1'b0 || done !== 1'b1 || core_reset !== 1'b0 || error !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: got we=%b done=%b crst=%b err=%b rdy=%b, required 0 1 0 0 0",
                     im_we, done, core_reset, error, in_ready);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL basic_writes: got %0d missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_gaps();
        pulse_load_req("gaps");
        exp_q.push_back({ADDR_W'(0), 32'h00100513});
        exp_q.push_back({ADDR_W'(1), 32'h00200593});
        send_byte(8'h02, 3); send_byte(8'h00, 3);
        send_byte(8'h13, 3); send_byte(8'h05, 3);
        // load_req mid-load must be ignored
        @(negedge CLK);
        load_req = 1'b1;
        @(posedge CLK);
        #1;
        load_req = 1'b0;
        total++;
        if (in_ready !== 1'b1 || core_reset !== 1'b1 || error !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL gaps_ignore_req: got rdy=%b crst=%b err=%b done=%b, required 1 1 0 0",
                     in_ready, core_reset, error, done);
        end
        send_byte(8'h10, 3); send_byte(8'h00, 3);
        send_byte(8'h93, 3); send_byte(8'h05, 3); send_byte(8'h20, 3); send_byte(8'h00, 3);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hB2, 3);
`endif
        wait_end(1'b1, "gaps");
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL gaps_writes: got %0d missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_empty();
        pulse_load_req("empty");
        send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        @(negedge CLK);
        total++;
        if (done !== 1'b1 || core_reset !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL empty_done: got done=%b crst=%b err=%b, required 1 0 0", done, core_reset, error);
        end
    endtask

    task automatic test_overflow();
        pulse_load_req("overflow");
        send_byte(8'h01, 0); send_byte(8'h04, 0);
        @(negedge CLK);
        total++;
        if (error !== 1'b1 || in_ready !== 1'b0 || core_reset !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL overflow_error: got err=%b rdy=%b crst=%b done=%b, required 1 0 1 0",
                     error, in_ready, core_reset, done);
        end
        repeat (3) @(negedge CLK);
        total++;
        if (error !== 1'b1) begin
            bad++;
            $display("FAIL overflow_hold: got err=%b, required 1", error);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pulse_load_req("ck_good");
        exp_q.push_back({ADDR_W'(0), 32'h00100513});
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        send_byte(8'h07, 0);
        @(negedge CLK);
        total++;
        if (done !== 1'b1 || error !== 1'b0 || core_reset !== 1'b0) begin
            bad++;
            $display("FAIL ck_good: got done=%b err=%b crst=%b, required 1 0 0", done, error, core_reset);
        end
        pulse_load_req("ck_bad");
        exp_q.push_back({ADDR_W'(0), 32'h00100513});
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        send_byte(8'h08, 0);
        @(negedge CLK);
        total++;
        if (done !== 1'b0 || error !== 1'b1 || core_reset !== 1'b1) begin
            bad++;
            $display("FAIL ck_bad: got done=%b err=%b crst=%b, required 0 1 1", done, error, core_reset);
        end
        pulse_load_req("ck_clear");
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        @(negedge CLK);
        total++;
        if (done !== 1'b1 || error !== 1'b0) begin
            bad++;
            $display("FAIL ck_xor_cleared: got done=%b err=%b, required 1 0", done, error);
        end
    endtask
`endif

    task automatic test_reload();
        logic [31:0] wq[$];
        pulse_load_req("reload");
        wq = {32'hDEADBEEF};
        load_image(wq, 0, "reload");
    endtask

    task automatic test_full();
        logic [31:0] wq[$];
        pulse_load_req("full");
        for (int i = 0; i < (1 << ADDR_W); i++) wq.push_back($urandom);
        load_image(wq, 0, "full");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_empty();
        test_overflow();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reload();
        test_full();
        repeat (3) @(negedge CLK);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_queue: got %0d pending writes, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
